cell_window_builder: RTL and testbench

Streaming front end for the cell processor. It accepts two raster-order pixel streams (A and B) in lockstep and buffers the previous two image lines of each. It emits fully populated 3x3 cells (cellA, cellB) with a valid/ready handshake, and these feed the cell processor's cellA/cellB inputs directly. Only interior windows are produced; there is no border padding.

---
 rtl/cell_window_builder_pkg.sv | 24 ++
 rtl/cell_window_builder_line_buffer.sv | 30 +++
 rtl/cell_window_builder.sv | 164 ++++++++++++++++
 tb/tb_cell_window_builder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cell_window_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : CellProcessingPkg
// Description : Shared pixel/cell types and frame defaults for cell processing
// Revision    : 1.0 - initial release
// ============================================================================
package CellProcessingPkg;

    localparam int c_IMG_WIDTH  = 640;
    localparam int c_IMG_HEIGHT = 480;
    localparam int c_PIXEL_W    = 8;

    // Index of the window centre inside pixelMatrix
    localparam int centerPixel  = 4;

    typedef logic [c_PIXEL_W-1:0] pixel_t;

    // pixelMatrix[3*r+c]: r=0 oldest line, c=0 oldest column; element 0 sits in the MSBs
    typedef struct packed {
        pixel_t [0:8] pixelMatrix;
    } cell_t;

endpackage
`default_nettype wire

// File: rtl/cell_window_builder_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Single-port circular line RAM, read-before-write at one address
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // The read returns the previous line's content at this column; the write lands at the edge
    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cell_window_builder.sv
`default_nettype none
// ============================================================================
// Module      : cell_window_builder
// Description : Builds interior 3x3 cells from two lockstep raster pixel streams
// Revision    : 1.0 - initial release
// ============================================================================
module cell_window_builder
    import CellProcessingPkg::*;
#(
    parameter int IMG_WIDTH  = c_IMG_WIDTH,
    parameter int IMG_HEIGHT = c_IMG_HEIGHT,
    parameter int PIXEL_W    = c_PIXEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sof,
    input  logic [PIXEL_W-1:0]   pixelA,
    input  logic [PIXEL_W-1:0]   pixelB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*PIXEL_W-1:0] cellA,
    output logic [9*PIXEL_W-1:0] cellB,
    output logic                 frame_done
);

    localparam int                 c_COL_W    = $clog2(IMG_WIDTH);
    localparam int                 c_ROW_W    = $clog2(IMG_HEIGHT);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   w_col;
    logic [c_ROW_W-1:0]   w_row;
    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_frame_last;
    logic                 w_emit;
    logic                 r_out_valid;
    logic                 r_frame_done;
    logic [9*PIXEL_W-1:0] r_cell_a;
    logic [9*PIXEL_W-1:0] r_cell_b;
    logic [PIXEL_W-1:0]   w_pix  [2];
    logic [9*PIXEL_W-1:0] w_cell [2];

    assign in_ready     = !rst && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;

    // Position of the pixel being accepted this cycle; sof overrides the running count
    assign w_col        = sof ? '0 : r_col;
    assign w_row        = sof ? '0 : r_row;
    assign w_col_last   = (w_col == c_COL_LAST);
    assign w_frame_last = w_col_last && (w_row == c_ROW_LAST);
    assign w_emit       = w_accept && (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));

    assign w_pix[0]     = pixelA;
    assign w_pix[1]     = pixelB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + c_ROW_W'(1);
            end else begin
                r_col <= w_col + c_COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_stream
            logic [PIXEL_W-1:0]   w_line1;
            logic [PIXEL_W-1:0]   w_line2;
            logic [PIXEL_W-1:0]   r_win  [3][3];
            logic [PIXEL_W-1:0]   w_next [3][3];
            logic [9*PIXEL_W-1:0] w_pack;

            line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_line1 (
                .clk       (clk),
                .i_en      (w_accept),
                .i_addr    (w_col),
                .i_wr_data (w_pix[s]),
                .o_rd_data (w_line1)
            );

            // Line row-1 ages into line row-2 as the new pixel replaces it
            line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_line2 (
                .clk       (clk),
                .i_en      (w_accept),
                .i_addr    (w_col),
                .i_wr_data (w_line1),
                .o_rd_data (w_line2)
            );

            always_comb begin
                for (int r = 0; r < 3; r++) begin
                    w_next[r][0] = r_win[r][1];
                    w_next[r][1] = r_win[r][2];
                end
                w_next[0][2] = w_line2;
                w_next[1][2] = w_line1;
                w_next[2][2] = w_pix[s];
            end

            always_comb begin
                w_pack = '0;
                for (int i = 0; i < 9; i++) begin
                    w_pack[(8-i)*PIXEL_W +: PIXEL_W] = w_next[i/3][i%3];
                end
            end

            assign w_cell[s] = w_pack;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            r_win[r][c] <= '0;
                        end
                    end
                end else if (w_accept) begin
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            r_win[r][c] <= w_next[r][c];
                        end
                    end
                end
            end
        end
    endgenerate

    // A fresh window may overwrite one being consumed in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_cell_a     <= '0;
            r_cell_b     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_frame_last;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_cell_a    <= w_cell[0];
                r_cell_b    <= w_cell[1];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign cellA      = r_cell_a;
    assign cellB      = r_cell_b;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_cell_window_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_window_builder
// Description : Directed self-checking bench for cell_window_builder (4x4 frames)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_window_builder;
    import CellProcessingPkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sof = 1'b0;
    logic [7:0]  pixelA = '0;
    logic [7:0]  pixelB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [71:0] cellA;
    logic [71:0] cellB;
    logic        frame_done;

    int          checks   = 0;
    int          failures = 0;
    logic [71:0] q_a [$];
    logic [71:0] q_b [$];

    cell_window_builder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sof        (sof),
        .pixelA     (pixelA),
        .pixelB     (pixelB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cellA      (cellA),
        .cellB      (cellB),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Record every window the consumer actually takes
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_a.push_back(cellA);
            q_b.push_back(cellB);
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window whose bottom-right pixel is (r,c); pixel value is 4*row+col+1+off
    function automatic logic [71:0] exp_cell(input int r, input int c, input int off);
        cell_t e;
        for (int i = 0; i < 9; i++) begin
            e.pixelMatrix[i] = pixel_t'(4*(r-2+i/3) + (c-2+i%3) + 1 + off);
        end
        return e;
    endfunction

    function automatic logic [7:0] center_of(input logic [71:0] v);
        cell_t t;
        t = v;
        return t.pixelMatrix[centerPixel];
    endfunction

    task automatic push(input int a, input int b, input logic s);
        int n;
        n = 0;
        pixelA   = 8'(a);
        pixelB   = 8'(b);
        sof      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic stream_frame(input logic first_sof, input string tag);
        int fd;
        fd = 0;
        for (int k = 0; k < 16; k++) begin
            push(k + 1, k + 101, first_sof && (k == 0));
            fd += int'(frame_done);
            if (k == 9)  chk({tag, "_no_early_valid"}, 72'(out_valid), 72'd0);
            if (k == 10) begin
                chk({tag, "_first_valid"},   72'(out_valid), 72'd1);
                chk({tag, "_first_cellA"},   cellA, exp_cell(2, 2, 0));
                chk({tag, "_first_centerB"}, 72'(center_of(cellB)), 72'd106);
            end
            if (k == 15) chk({tag, "_frame_done_last"}, 72'(frame_done), 72'd1);
        end
        chk({tag, "_frame_done_count"}, 72'(fd), 72'd1);
    endtask

    task automatic check_windows(input string tag, input int n);
        int idx;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_window_count"}, 72'(q_a.size()), 72'(n));
        for (int i = 0; i < n && i < q_a.size(); i++) begin
            idx = i % 4;
            chk($sformatf("%s_win%0d_A", tag, i), q_a[i], exp_cell(2 + idx/2, 2 + idx%2, 0));
            chk($sformatf("%s_win%0d_B", tag, i), q_b[i], exp_cell(2 + idx/2, 2 + idx%2, 100));
        end
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        int bad;
        int early;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid",  72'(out_valid),  72'd0);
        chk("reset_cellA",      cellA,           72'd0);
        chk("reset_cellB",      cellB,           72'd0);
        chk("reset_frame_done", 72'(frame_done), 72'd0);
        chk("reset_in_ready",   72'(in_ready),   72'd0);
        rst = 1'b0;

        // Two frames back to back, only the first carries sof
        stream_frame(1'b1, "f1");
        stream_frame(1'b0, "f2");
        check_windows("b2b", 8);
        chk("last_center", 72'(center_of(exp_cell(3, 3, 0))), 72'd11);

        // Backpressure after the first window
        for (int k = 0; k < 11; k++) push(k + 1, k + 101, k == 0);
        out_ready = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || cellA !== exp_cell(2, 2, 0)) bad++;
        end
        chk("bp_hold_bad_cycles", 72'(bad), 72'd0);
        chk("bp_in_ready",        72'(in_ready), 72'd0);
        chk("bp_cellA",           cellA, exp_cell(2, 2, 0));
        out_ready = 1'b1;
        for (int k = 11; k < 16; k++) push(k + 1, k + 101, 1'b0);
        check_windows("bp", 4);

        // Aborted frame with distinct data, then sof on the 7th pixel
        for (int k = 0; k < 6; k++) push(200 + k, 150 + k, k == 0);
        early = 0;
        for (int k = 0; k < 16; k++) begin
            push(k + 1, k + 101, k == 0);
            if (k < 10 && out_valid) early++;
            if (k == 10) begin
                chk("sof_first_valid",   72'(out_valid), 72'd1);
                chk("sof_first_centerA", 72'(center_of(cellA)), 72'd6);
                chk("sof_first_cellA",   cellA, exp_cell(2, 2, 0));
            end
        end
        chk("sof_early_windows", 72'(early), 72'd0);
        check_windows("sof_mid", 4);

        // Asynchronous reset while a window is pending
        for (int k = 0; k < 11; k++) push(k + 1, k + 101, k == 0);
        chk("prerst_valid", 72'(out_valid), 72'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 72'(out_valid), 72'd0);
        chk("async_rst_cellA",     cellA,          72'd0);
        chk("async_rst_in_ready",  72'(in_ready),  72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        stream_frame(1'b0, "post_rst");
        check_windows("post_rst", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
